fifo_param: RTL and testbench

Parametrised synchronous FIFO; next-generation replacement for the fixed 8-bit, fixed-depth FIFO top in the lab datapath. Single clock domain, configurable data width and depth, programmable almost-full/almost-empty thresholds and a live occupancy count. Sits between a producer driving active-low write strobes and a consumer driving active-low read strobes. Memory is a separate dual-port array.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_ram.sv | 38 +++
 rtl/fifo_param.sv | 126 ++++++++++++
 tb/tb_fifo_param.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and width helpers for the parametrised FIFO.
package fifo_pkg;

   localparam int unsigned DefDataWidth = 8;
   localparam int unsigned DefDepth     = 1024;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

   // One extra bit so the count can represent a completely full FIFO.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array with a registered read port feeding DOUT.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned DEPTH      = DefDepth
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [ptr_width(DEPTH)-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0]         wr_data,
   input  logic                          rd_en,
   input  logic [ptr_width(DEPTH)-1:0]   rd_addr,
   output logic [DATA_WIDTH-1:0]         rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   // The array itself is never reset; only the output register is.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO: pointers, occupancy count and status flags.
// Optional sticky OVERFLOW/UNDERFLOW outputs are enabled by FIFO_ERR_FLAGS_EN.
module fifo_param
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned DEPTH      = DefDepth,
   parameter int unsigned AF_LEVEL   = DEPTH - 4,
   parameter int unsigned AE_LEVEL   = 4
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [DATA_WIDTH-1:0]         DIN,
   input  logic                          WE_N,
   input  logic                          OE_N,
   output logic [DATA_WIDTH-1:0]         DOUT,
   output logic                          FULL,
   output logic                          EMPTY,
   output logic                          ALMOST_FULL,
   output logic                          ALMOST_EMPTY,
   output logic [cnt_width(DEPTH)-1:0]   COUNT
`ifdef FIFO_ERR_FLAGS_EN
   ,
   output logic                          OVERFLOW,
   output logic                          UNDERFLOW
`endif
);

   localparam int unsigned PtrW = ptr_width(DEPTH);
   localparam int unsigned CntW = cnt_width(DEPTH);

   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;
   logic            full_q, empty_q, afull_q, aempty_q;
   logic            full_d, empty_d, afull_d, aempty_d;
   logic            wr_acc, rd_acc;

   // Acceptance uses the registered flags, so a full FIFO still reads and an
   // empty one still writes when both strobes are low together.
   assign wr_acc = ~RST & ~WE_N & ~full_q;
   assign rd_acc = ~RST & ~OE_N & ~empty_q;

   always_comb begin
      count_d = count_q;
      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      full_d   = (count_d == CntW'(DEPTH));
      empty_d  = (count_d == '0);
      afull_d  = (count_d >= CntW'(AF_LEVEL));
      aempty_d = (count_d <= CntW'(AE_LEVEL));
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
      end else begin
         if (wr_acc) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (rd_acc) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
      end
   end

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk     (CLK),
      .rst     (RST),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr_q),
      .wr_data (DIN),
      .rd_en   (rd_acc),
      .rd_addr (rd_ptr_q),
      .rd_data (DOUT)
   );

   assign FULL         = full_q;
   assign EMPTY        = empty_q;
   assign ALMOST_FULL  = afull_q;
   assign ALMOST_EMPTY = aempty_q;
   assign COUNT        = count_q;

`ifdef FIFO_ERR_FLAGS_EN
   logic ovf_q, udf_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (~WE_N & full_q) begin
            ovf_q <= 1'b1;
         end
         if (~OE_N & empty_q) begin
            udf_q <= 1'b1;
         end
      end
   end

   assign OVERFLOW  = ovf_q;
   assign UNDERFLOW = udf_q;
`else
   // Rejected requests are simply dropped; no error state is kept.
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param (DATA_WIDTH=8, DEPTH=16) against a queue model.
// Error-flag checks are included when FIFO_ERR_FLAGS_EN is defined.
module tb_fifo_param;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AFL   = 12;
   localparam int unsigned AEL   = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [DW-1:0] DIN = '0;
   logic          WE_N = 1'b1;
   logic          OE_N = 1'b1;
   logic [DW-1:0] DOUT;
   logic          FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY;
   logic [4:0]    COUNT;
`ifdef FIFO_ERR_FLAGS_EN
   logic          OVERFLOW, UNDERFLOW;
`endif

   fifo_param #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .AF_LEVEL   (AFL),
      .AE_LEVEL   (AEL)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .DIN          (DIN),
      .WE_N         (WE_N),
      .OE_N         (OE_N),
      .DOUT         (DOUT),
      .FULL         (FULL),
      .EMPTY        (EMPTY),
      .ALMOST_FULL  (ALMOST_FULL),
      .ALMOST_EMPTY (ALMOST_EMPTY),
      .COUNT        (COUNT)
`ifdef FIFO_ERR_FLAGS_EN
      ,
      .OVERFLOW     (OVERFLOW),
      .UNDERFLOW    (UNDERFLOW)
`endif
   );

   always #5 CLK = ~CLK;

   // Behavioural model: a queue of stored words plus the last word read.
   logic [DW-1:0] q[$];
   logic [DW-1:0] dout_m = '0;
   logic          ovf_m = 1'b0;
   logic          udf_m = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic check_all();
      chk("count", 32'(COUNT), 32'(q.size()));
      chk("empty", 32'(EMPTY), 32'(q.size() == 0));
      chk("full", 32'(FULL), 32'(q.size() == DEPTH));
      chk("almost_full", 32'(ALMOST_FULL), 32'(q.size() >= AFL));
      chk("almost_empty", 32'(ALMOST_EMPTY), 32'(q.size() <= AEL));
      chk("dout", 32'(DOUT), 32'(dout_m));
`ifdef FIFO_ERR_FLAGS_EN
      chk("overflow", 32'(OVERFLOW), 32'(ovf_m));
      chk("underflow", 32'(UNDERFLOW), 32'(udf_m));
`endif
   endtask

   // Apply one cycle of stimulus, advance the model across the edge, then check.
   task automatic step(input logic rst, input logic we_n, input logic oe_n,
                       input logic [DW-1:0] din);
      bit was_full, was_empty;
      RST  = rst;
      WE_N = we_n;
      OE_N = oe_n;
      DIN  = din;
      @(posedge CLK);
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (rst) begin
         q.delete();
         dout_m = '0;
         ovf_m  = 1'b0;
         udf_m  = 1'b0;
      end else begin
         if (!we_n && was_full)  ovf_m = 1'b1;
         if (!oe_n && was_empty) udf_m = 1'b1;
         if (!oe_n && !was_empty) dout_m = q.pop_front();
         if (!we_n && !was_full)  q.push_back(din);
      end
      #1;
      check_all();
   endtask

   initial begin
      // Reset then idle.
      step(1'b1, 1'b1, 1'b1, 8'h00);
      step(1'b1, 1'b1, 1'b1, 8'h00);
      step(1'b0, 1'b1, 1'b1, 8'h00);
      step(1'b0, 1'b1, 1'b1, 8'h00);

      // Fill with 0x00..0x0F, then one dropped write of 0x10.
      for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 8'(i));
      step(1'b0, 1'b0, 1'b1, 8'h10);

      // Drain all 16, then one extra read that must leave DOUT at 0x0F.
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk("dout_hold", 32'(DOUT), 32'h0F);

      // Hold occupancy at 8 with simultaneous traffic so the pointers wrap.
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 8'($urandom));
      for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0, 8'($urandom));
      chk("count_steady", 32'(COUNT), 32'd8);

      // Full plus simultaneous read/write: write dropped.
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 8'($urandom));
      step(1'b0, 1'b0, 1'b0, 8'hA5);
      chk("count_full_rw", 32'(COUNT), 32'd15);

      // Empty plus simultaneous read/write: read dropped, DOUT unchanged.
      for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h5A);
      chk("count_empty_rw", 32'(COUNT), 32'd1);

      // Randomised traffic, write-biased then read-biased to hit both limits.
      for (int i = 0; i < 150; i++)
         step(1'b0, 1'(($urandom % 4) == 0), 1'(($urandom % 4) != 0), 8'($urandom));
      for (int i = 0; i < 150; i++)
         step(1'b0, 1'(($urandom % 4) != 0), 1'(($urandom % 4) == 0), 8'($urandom));
      for (int i = 0; i < 150; i++)
         step(1'b0, 1'($urandom % 2), 1'($urandom % 2), 8'($urandom));

`ifdef FIFO_ERR_FLAGS_EN
      // Provoke both sticky flags explicitly.
      while (q.size() < DEPTH) step(1'b0, 1'b0, 1'b1, 8'($urandom));
      step(1'b0, 1'b0, 1'b1, 8'hEE);
      step(1'b0, 1'b1, 1'b1, 8'h00);
      while (q.size() > 0) step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b1, 8'h00);
`endif

      // Reset mid-fill discards contents; requests in the reset cycle are ignored.
      step(1'b1, 1'b1, 1'b1, 8'h00);
      for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, 8'($urandom));
      chk("count_midfill", 32'(COUNT), 32'd9);
      step(1'b1, 1'b0, 1'b0, 8'h77);
      chk("count_after_rst", 32'(COUNT), 32'd0);
      step(1'b0, 1'b1, 1'b1, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
